// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared defaults and FSM state encoding for the program loader, CPU top and bench
package imem_loader_pkg;
    localparam int          MEM_SIZE_DEF   = 256;
    localparam logic [31:0] ADDR_MASK_DEF  = 32'hFFBFFFFF;
    localparam int          BYTES_PER_WORD = 4;
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_LOAD  = 2'd1;
    localparam logic [1:0]  S_WRITE = 2'd2;
    localparam logic [1:0]  S_RUN   = 2'd3;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs accepted bytes little-endian into 32-bit words
// Ports: clk/rst_n (sync, active-low), i_clear restarts a word, i_byte_valid/i_byte accepted byte,
//        o_word assembled word, o_word_ready pulses with the byte that completes a word
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);
    logic [1:0]  r_cnt;
    logic [31:0] r_sr;
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_cnt <= '0;
            r_sr  <= '0;
        end else if (i_byte_valid) begin
            r_cnt <= r_cnt + 2'd1;
            // shifting in from the top leaves byte 0 in [7:0] after four bytes
            r_sr  <= {i_byte, r_sr[31:8]};
        end
    end
    assign o_word       = r_sr;
    assign o_word_ready = i_byte_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a program from a byte stream into instruction memory, then serves CPU fetches
// Ports: clk, rst_n (sync, active-low); start/len_words begin a load; rx_valid/rx_data/rx_ready byte stream;
//        fetch_req/fetch_addr CPU request, fetch_data/fetch_valid/fetch_fault registered response;
//        mem_addr/mem_wdata/mem_we/mem_rdata external memory; cpu_stall, load_done, load_err status
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEM_SIZE  = MEM_SIZE_DEF,
    parameter logic [31:0] ADDR_MASK = ADDR_MASK_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [$clog2(MEM_SIZE):0]   len_words,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_data,
    output logic                        rx_ready,
    input  logic                        fetch_req,
    input  logic [31:0]                 fetch_addr,
    output logic [31:0]                 fetch_data,
    output logic                        fetch_valid,
    output logic                        fetch_fault,
    output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
    output logic [31:0]                 mem_wdata,
    output logic                        mem_we,
    input  logic [31:0]                 mem_rdata,
    output logic                        cpu_stall,
    output logic                        load_done,
    output logic                        load_err
);
    localparam int AW = $clog2(MEM_SIZE);
    localparam int LW = AW + 1;
    logic [1:0]    r_state;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_word_cnt;
    logic          r_load_err;
    logic          r_fetch_valid;
    logic          r_fetch_fault;
    logic [31:0]   r_fetch_data;
    logic          w_accept;
    logic          w_len_bad;
    logic          w_len_zero;
    logic          w_begin;
    logic          w_last;
    logic          w_in_range;
    logic [31:0]   w_idx;
    logic [31:0]   w_word;
    logic          w_word_ready;
    assign w_accept   = start && (r_state == S_IDLE || r_state == S_RUN);
    assign w_len_bad  = len_words > LW'(MEM_SIZE);
    assign w_len_zero = len_words == '0;
    assign w_begin    = w_accept && !w_len_bad && !w_len_zero;
    // word counter is one bit wider than the address so a full-depth load cannot wrap
    assign w_last     = (r_word_cnt + 1'b1) == r_len;
    assign w_idx      = (fetch_addr & ADDR_MASK) >> 2;
    assign w_in_range = w_idx < 32'(MEM_SIZE);
    word_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_begin),
        .i_byte_valid (rx_valid && rx_ready),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_word_cnt    <= '0;
            r_load_err    <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
            r_fetch_data  <= '0;
        end else begin
            r_fetch_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
            r_fetch_data  <= '0;
            // start takes priority over a coincident fetch, which then gets no response
            if (w_accept) begin
                r_state    <= w_len_bad ? S_IDLE : (w_len_zero ? S_RUN : S_LOAD);
                r_load_err <= w_len_bad;
                if (!w_len_bad) begin
                    r_len      <= len_words;
                    r_word_cnt <= '0;
                end
            end else if (r_state == S_LOAD && w_word_ready) begin
                r_state <= S_WRITE;
            end else if (r_state == S_WRITE) begin
                r_word_cnt <= r_word_cnt + 1'b1;
                r_state    <= w_last ? S_RUN : S_LOAD;
            end else if (r_state == S_RUN && fetch_req) begin
                r_fetch_valid <= 1'b1;
                r_fetch_fault <= !w_in_range;
                r_fetch_data  <= w_in_range ? mem_rdata : '0;
            end
        end
    end
    assign rx_ready    = r_state == S_LOAD;
    assign mem_we      = r_state == S_WRITE;
    assign mem_wdata   = mem_we ? w_word : '0;
    assign mem_addr    = mem_we ? r_word_cnt[AW-1:0] : (r_state == S_RUN ? w_idx[AW-1:0] : '0);
    assign cpu_stall   = r_state != S_RUN;
    assign load_done   = r_state == S_RUN;
    assign load_err    = r_load_err;
    assign fetch_valid = r_fetch_valid;
    assign fetch_fault = r_fetch_fault;
    assign fetch_data  = r_fetch_data;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader with a behavioural memory
module tb_imem_loader;
    import imem_loader_pkg::*;
    localparam int MS = MEM_SIZE_DEF;
    localparam int AW = $clog2(MS);
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len_words = '0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_ready;
    logic          fetch_req = 1'b0;
    logic [31:0]   fetch_addr = '0;
    logic [31:0]   fetch_data;
    logic          fetch_valid;
    logic          fetch_fault;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    logic          cpu_stall;
    logic          load_done;
    logic          load_err;
    logic [31:0]   mem [MS];
    logic [AW-1:0] last_wa = '0;
    int            n_we = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [31:0]   wd;

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len_words(len_words),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .fetch_valid(fetch_valid), .fetch_fault(fetch_fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .cpu_stall(cpu_stall), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            n_we          <= n_we + 1;
            last_wa       <= mem_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int w);
        return 32'hA5000000 ^ (32'(w) * 32'h01010101);
    endfunction

    initial begin
        step();
        step();
        chk("rst_stall", 32'(cpu_stall), 1);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_err", 32'(load_err), 0);
        chk("rst_rx_ready", 32'(rx_ready), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_fvalid", 32'(fetch_valid), 0);
        chk("rst_ffault", 32'(fetch_fault), 0);
        chk("rst_fdata", fetch_data, 0);
        chk("rst_maddr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        step();
        chk("idle_stall", 32'(cpu_stall), 1);
        // two-word load, second word's first byte held across WRITE
        start = 1'b1; len_words = 9'd2;
        step();
        start = 1'b0;
        chk("load_rx_ready", 32'(rx_ready), 1);
        chk("load_stall", 32'(cpu_stall), 1);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        chk("w0_we", 32'(mem_we), 1);
        chk("w0_addr", 32'(mem_addr), 0);
        chk("w0_wdata", mem_wdata, 32'h12345678);
        chk("w0_rx_ready", 32'(rx_ready), 0);
        rx_valid = 1'b1; rx_data = 8'hEF;
        step();
        chk("w0_we_off", 32'(mem_we), 0);
        chk("mem0", mem[0], 32'h12345678);
        step();
        rx_data = 8'hBE; step();
        rx_data = 8'hAD; step();
        rx_data = 8'hDE; step();
        rx_valid = 1'b0;
        chk("w1_we", 32'(mem_we), 1);
        chk("w1_addr", 32'(mem_addr), 1);
        chk("w1_wdata", mem_wdata, 32'hDEADBEEF);
        chk("w1_done_pre", 32'(load_done), 0);
        step();
        chk("run_done", 32'(load_done), 1);
        chk("run_stall", 32'(cpu_stall), 0);
        chk("run_rx_ready", 32'(rx_ready), 0);
        chk("mem1", mem[1], 32'hDEADBEEF);
        chk("we_count2", n_we, 2);
        // fetches
        fetch_req = 1'b1; fetch_addr = 32'h00400004;
        #1;
        chk("f_maddr", 32'(mem_addr), 1);
        chk("f_valid_pre", 32'(fetch_valid), 0);
        step();
        chk("f1_valid", 32'(fetch_valid), 1);
        chk("f1_data", fetch_data, 32'hDEADBEEF);
        chk("f1_fault", 32'(fetch_fault), 0);
        fetch_addr = 32'h00000000;
        step();
        chk("f0_data", fetch_data, 32'h12345678);
        fetch_addr = 32'h00000400;
        step();
        fetch_req = 1'b0;
        chk("fo_valid", 32'(fetch_valid), 1);
        chk("fo_data", fetch_data, 0);
        chk("fo_fault", 32'(fetch_fault), 1);
        step();
        chk("f_idle_valid", 32'(fetch_valid), 0);
        chk("f_idle_fault", 32'(fetch_fault), 0);
        // oversize start coinciding with a fetch in RUN
        start = 1'b1; len_words = 9'd257; fetch_req = 1'b1; fetch_addr = 32'h4;
        step();
        start = 1'b0;
        chk("big_fvalid", 32'(fetch_valid), 0);
        chk("big_err", 32'(load_err), 1);
        chk("big_stall", 32'(cpu_stall), 1);
        chk("big_done", 32'(load_done), 0);
        step();
        chk("idle_fvalid", 32'(fetch_valid), 0);
        chk("idle_we", 32'(mem_we), 0);
        chk("big_we_count", n_we, 2);
        fetch_req = 1'b0;
        // zero-length start goes straight to RUN
        start = 1'b1; len_words = 9'd0;
        step();
        start = 1'b0;
        chk("zero_done", 32'(load_done), 1);
        chk("zero_err", 32'(load_err), 0);
        chk("zero_stall", 32'(cpu_stall), 0);
        // reload from RUN, then reset with a partial word
        start = 1'b1; len_words = 9'd1;
        step();
        start = 1'b0;
        chk("reload_stall", 32'(cpu_stall), 1);
        chk("reload_done", 32'(load_done), 0);
        send_byte(8'hAA); send_byte(8'hBB);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_rx_ready", 32'(rx_ready), 0);
        chk("mid_rst_stall", 32'(cpu_stall), 1);
        chk("mid_rst_we_count", n_we, 2);
        send_byte(8'hFF);
        chk("idle_byte_ignored", 32'(rx_ready), 0);
        start = 1'b1; len_words = 9'd1;
        step();
        start = 1'b0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("fresh_we", 32'(mem_we), 1);
        chk("fresh_addr", 32'(mem_addr), 0);
        chk("fresh_wdata", mem_wdata, 32'h04030201);
        step();
        chk("fresh_done", 32'(load_done), 1);
        chk("fresh_mem0", mem[0], 32'h04030201);
        chk("fresh_we_count", n_we, 3);
        // full-depth load with ignored starts during LOAD and WRITE
        start = 1'b1; len_words = 9'd256;
        step();
        start = 1'b0;
        for (int w = 0; w < MS; w++) begin
            wd = pat(w);
            for (int b = 0; b < 4; b++) begin
                start = (w == 5 && b == 0);
                len_words = start ? 9'd3 : 9'd256;
                send_byte(wd[8*b +: 8]);
                start = 1'b0;
            end
            chk("full_we", 32'(mem_we), 1);
            chk("full_addr", 32'(mem_addr), 32'(w));
            start = (w == 9);
            step();
            start = 1'b0;
        end
        chk("full_done", 32'(load_done), 1);
        chk("full_last_addr", 32'(last_wa), 255);
        chk("full_we_count", n_we, 259);
        chk("full_mem255", mem[255], pat(255));
        chk("full_mem5", mem[5], pat(5));
        chk("full_mem10", mem[10], pat(10));
        fetch_req = 1'b1; fetch_addr = 32'h004003FC;
        step();
        fetch_req = 1'b0;
        chk("f255_valid", 32'(fetch_valid), 1);
        chk("f255_data", fetch_data, pat(255));
        chk("f255_fault", 32'(fetch_fault), 0);
        start = 1'b1; len_words = 9'd1;
        step();
        start = 1'b0;
        chk("reload2_stall", 32'(cpu_stall), 1);
        chk("reload2_rx_ready", 32'(rx_ready), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_SIZE, default 256, gives the instruction memory depth in 32-bit words.
REQ-002 Parameter ADDR_MASK, default 32'hFFBFFFFF, is the mask applied to the fetch byte address before word indexing.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port start, input, 1 bit: single-cycle pulse that begins a program load.
REQ-006 Port len_words, input, clog2(MEM_SIZE)+1 bits: number of words to load, sampled when start is accepted.
REQ-007 Ports rx_valid (input, 1), rx_data (input, 8) and rx_ready (output, 1) form the program byte stream; a byte transfers when rx_valid and rx_ready are both 1.
REQ-008 Ports fetch_req (input, 1) and fetch_addr (input, 32): fetch request from the CPU, carrying a byte address.
REQ-009 Ports fetch_data (output, 32), fetch_valid (output, 1) and fetch_fault (output, 1): registered fetch response.
REQ-010 Ports mem_addr (output, clog2(MEM_SIZE)), mem_wdata (output, 32), mem_we (output, 1) and mem_rdata (input, 32) connect to the memory; the read is combinational, the write is synchronous.
REQ-011 Port cpu_stall, output, 1 bit: holds the CPU while no valid program is present.
REQ-012 Port load_done, output, 1 bit: a program is loaded and fetch is enabled.
REQ-013 Port load_err, output, 1 bit: the last start was rejected.

Function
REQ-014 The FSM SHALL have four states: IDLE, LOAD, WRITE, RUN.
REQ-015 In IDLE, a start with len_words == 0 SHALL go to RUN.
REQ-016 In IDLE, a start with len_words > MEM_SIZE SHALL stay in IDLE and set load_err.
REQ-017 In IDLE, any other start SHALL latch len_words, clear the word and byte counters and load_err, and go to LOAD.
REQ-018 In LOAD, rx_ready SHALL be 1.
- Accepted bytes are assembled little-endian: byte 0 goes to bits [7:0], byte 3 to bits [31:24].
- When the 4th byte is accepted, the FSM goes to WRITE.
REQ-019 In WRITE, exactly one cycle:
- mem_we=1, mem_addr=word_cnt, mem_wdata=assembled word, rx_ready=0.
- word_cnt is incremented.
- Next state is RUN if word_cnt+1 == latched length, else LOAD.
REQ-020 In RUN: cpu_stall=0, load_done=1, rx_ready=0.
- mem_addr=((fetch_addr & ADDR_MASK) >> 2), truncated to the mem_addr width.
REQ-021 Fetch latency SHALL be 1 cycle: fetch_valid is asserted in the cycle after fetch_req when in RUN.
- fetch_data=mem_rdata when the shifted index < MEM_SIZE.
- Otherwise fetch_data=0 and fetch_fault=1.
REQ-022 Outside RUN, fetch_req SHALL be ignored: fetch_valid=0 and mem_we is never driven by the fetch path.
REQ-023 start in RUN SHALL behave as in IDLE (reload), with cpu_stall=1 from the next cycle.
- If that start is rejected for length, the FSM goes to IDLE with load_done=0 and load_err=1.
REQ-024 start in LOAD or WRITE SHALL be ignored.
REQ-025 When start coincides with fetch_req in RUN, start SHALL win and no fetch response is issued.
REQ-026 A load of exactly MEM_SIZE words SHALL write the last address MEM_SIZE-1, and word_cnt SHALL not wrap before the transition to RUN.
REQ-027 rx_valid held high across the WRITE cycle SHALL not lose or duplicate a byte, because rx_ready=0 in WRITE.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL enter IDLE, with:
- cpu_stall=1; load_done=0; load_err=0;
- rx_ready=0; mem_we=0; fetch_valid=0; fetch_fault=0;
- fetch_data=0; mem_addr=0; mem_wdata=0;
- all counters 0.
REQ-029 Reset asserted mid-LOAD SHALL abandon the partial word with no write, and a new start is required.
REQ-030 Memory contents SHALL not be cleared by reset.

Structure
REQ-031 The FSM state encoding, ADDR_MASK default and MEM_SIZE default SHALL live in a shared package, also used by the CPU top and the bench.
REQ-032 Byte-to-word assembly SHALL be one sub-module, word_assembler, containing the byte counter, the shift register and a word_ready pulse.
REQ-033 The memory array SHALL be outside this block.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- start, len=2, bytes 78 56 34 12 EF BE AD DE -> mem[0]=12345678 and mem[1]=DEADBEEF, each with a 1-cycle mem_we; load_done=1 the cycle after the second WRITE.
- In RUN, fetch_req with addr 0x00400004 -> mask gives index 1 -> fetch_data=DEADBEEF, fetch_valid=1 one cycle later.
- fetch addr 0x00000400 with MEM_SIZE=256 -> fetch_data=0, fetch_fault=1.
- start with len=257 -> load_err=1, cpu_stall=1, no mem_we; start with len=0 -> RUN immediately.
- rst_n=0 after 2 bytes of word 0, then start len=1 with bytes 01 02 03 04 -> mem[0]=04030201, with no stale bytes.
- Load of 256 words -> last write at addr 255; start during LOAD is ignored; start in RUN reloads, with cpu_stall=1.
